// File: rtl/host_block_reader.sv
// SPI mode-0 master that fetches one BLOCKSIZE-byte block from the FPGA sample FIFO
// when rdy is seen, and issues a FIFO-clear command on request.
module host_block_reader #(
  parameter int         BLOCKSIZE = 8192,
  parameter int         CLKDIV    = 4,
  parameter int         GAP       = 16,
  parameter logic [7:0] CMD_READ  = 8'h01,
  parameter logic [7:0] CMD_CLR   = 8'h02
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       enable,
  input  logic                       clr_req,
  input  logic                       rdy,
  input  logic                       miso,
  output logic                       sck,
  output logic                       mosi,
  output logic [7:0]                 rdata,
  output logic                       rvalid,
  output logic                       busy,
  output logic                       block_done,
  output logic [$clog2(BLOCKSIZE):0] byte_cnt
);

  localparam int CNT_W = $clog2(BLOCKSIZE) + 1;
  localparam int DIV_W = $clog2(CLKDIV);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             rdy_meta_q, rdy_s_q;
  logic             miso_meta_q, miso_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             sck_q, sck_d;
  logic [7:0]       tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic             is_clr_q, is_clr_d;
  logic             clr_pend_q, clr_pend_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             block_done_q, block_done_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic half_end;
  logic sample;
  logic bit_end;

  // Sampling happens in the first high cycle of sck so the two-stage miso
  // synchronizer has caught up with data launched on the previous falling edge.
  assign half_end = (div_q == DIV_W'(CLKDIV - 1));
  assign sample   = sck_q && (div_q == '0);
  assign bit_end  = sck_q && half_end;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    sck_d        = sck_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    is_clr_d     = is_clr_q;
    clr_pend_d   = clr_pend_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    block_done_d = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    gap_d        = gap_q;

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        sck_d = 1'b0;
        gap_d = '0;
        if (clr_pend_q) begin
          state_d    = S_CMD;
          is_clr_d   = 1'b1;
          tx_d       = CMD_CLR;
          byte_cnt_d = '0;
        end else if (enable && rdy_s_q) begin
          state_d    = S_CMD;
          is_clr_d   = 1'b0;
          tx_d       = CMD_READ;
          byte_cnt_d = '0;
        end
      end

      S_CMD, S_DATA: begin
        if (half_end) begin
          div_d = '0;
          sck_d = ~sck_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        if (state_q == S_DATA && sample) begin
          rx_d = {rx_q[5:0], miso_s_q};
          if (bit_q == 3'd7) begin
            rdata_d      = {rx_q, miso_s_q};
            rvalid_d     = 1'b1;
            byte_cnt_d   = byte_cnt_q + CNT_W'(1);
            block_done_d = (byte_cnt_q == CNT_W'(BLOCKSIZE - 1));
          end
        end

        // Bit boundary: falling sck; the next mosi bit is presented now.
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            if (state_q == S_CMD) begin
              if (is_clr_q) begin
                clr_pend_d = 1'b0;
                state_d    = S_GAP;
              end else begin
                state_d = S_DATA;
              end
            end else if (byte_cnt_q == CNT_W'(BLOCKSIZE)) begin
              state_d = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP - 1)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A new request wins over the completion clear so a request landing on
    // the last CLR bit is deferred rather than lost.
    if (clr_req) clr_pend_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= S_IDLE;
      rdy_meta_q   <= 1'b0;
      rdy_s_q      <= 1'b0;
      miso_meta_q  <= 1'b0;
      miso_s_q     <= 1'b0;
      div_q        <= '0;
      bit_q        <= '0;
      sck_q        <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      is_clr_q     <= 1'b0;
      clr_pend_q   <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      block_done_q <= 1'b0;
      byte_cnt_q   <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      rdy_meta_q   <= rdy;
      rdy_s_q      <= rdy_meta_q;
      miso_meta_q  <= miso;
      miso_s_q     <= miso_meta_q;
      div_q        <= div_d;
      bit_q        <= bit_d;
      sck_q        <= sck_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      is_clr_q     <= is_clr_d;
      clr_pend_q   <= clr_pend_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      block_done_q <= block_done_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_q        <= gap_d;
    end
  end

  assign sck        = sck_q;
  assign mosi       = tx_q[7];
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign busy       = (state_q != S_IDLE);
  assign block_done = block_done_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_host_block_reader.sv
// Directed bench for host_block_reader: small block, fast divider, behavioural
// SPI slave that launches each miso bit on falling sck.
module tb_host_block_reader;

  localparam int BLOCKSIZE = 4;
  localparam int CLKDIV    = 2;
  localparam int GAP       = 16;
  localparam int CNT_W     = $clog2(BLOCKSIZE) + 1;

  logic             clk = 1'b0;
  logic             arstn;
  logic             enable;
  logic             clr_req;
  logic             rdy;
  logic             miso = 1'b0;
  logic             sck;
  logic             mosi;
  logic [7:0]       rdata;
  logic             rvalid;
  logic             busy;
  logic             block_done;
  logic [CNT_W-1:0] byte_cnt;

  always #5 clk = ~clk;

  host_block_reader #(
    .BLOCKSIZE (BLOCKSIZE),
    .CLKDIV    (CLKDIV),
    .GAP       (GAP),
    .CMD_READ  (8'h01),
    .CMD_CLR   (8'h02)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .enable     (enable),
    .clr_req    (clr_req),
    .rdy        (rdy),
    .miso       (miso),
    .sck        (sck),
    .mosi       (mosi),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy),
    .block_done (block_done),
    .byte_cnt   (byte_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: after the 8 command falls, each falling sck presents the next data bit MSB first.
  logic [7:0] slave_data [4];
  int         fall_cnt = 0;
  initial begin
    slave_data[0] = 8'hA5;
    slave_data[1] = 8'h3C;
    slave_data[2] = 8'h00;
    slave_data[3] = 8'hFF;
  end

  always @(negedge sck or negedge busy) begin
    int idx;
    if (!busy) begin
      fall_cnt = 0;
      miso     = 1'b0;
    end else begin
      fall_cnt++;
      idx = fall_cnt - 8;
      if (idx >= 0 && idx < 8 * BLOCKSIZE) miso = slave_data[idx / 8][7 - (idx % 8)];
      else miso = 1'b0;
    end
  end

  // Monitors: received bytes with their done flag and count, and mosi at each rising sck.
  logic [7:0] rx_bytes [$];
  int         rx_done  [$];
  int         rx_cnt   [$];
  logic       mosi_bits[$];

  always @(posedge clk) begin
    #1;
    if (rvalid === 1'b1) begin
      rx_bytes.push_back(rdata);
      rx_done.push_back(int'(block_done));
      rx_cnt.push_back(int'(byte_cnt));
    end
  end

  always @(posedge sck) begin
    #1;
    mosi_bits.push_back(mosi);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(tag, busy, lvl);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_cmd(input int base, input logic [7:0] exp, input string tag);
    logic [7:0] c = '0;
    check({tag, "_nbits"}, (mosi_bits.size() >= base + 8) ? 1 : 0, 1);
    if (mosi_bits.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) c = {c[6:0], mosi_bits[base + i]};
      check(tag, c, exp);
    end
  endtask

  task automatic check_block(input int base, input string tag);
    check({tag, "_count"}, rx_bytes.size() - base, BLOCKSIZE);
    if (rx_bytes.size() >= base + BLOCKSIZE) begin
      for (int i = 0; i < BLOCKSIZE; i++) begin
        check($sformatf("%s_byte%0d", tag, i), rx_bytes[base + i], slave_data[i]);
        check($sformatf("%s_done%0d", tag, i), rx_done[base + i], (i == BLOCKSIZE - 1) ? 1 : 0);
        check($sformatf("%s_cnt%0d", tag, i), rx_cnt[base + i], i + 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sck"}, sck, 0);
    check({tag, "_mosi"}, mosi, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_block_done"}, block_done, 0);
    check({tag, "_byte_cnt"}, byte_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rxb, mb, n, seen;

    arstn   = 1'b1;
    enable  = 1'b0;
    clr_req = 1'b0;
    rdy     = 1'b0;
    #1 arstn = 1'b0;
    #20;
    check_reset_outputs("por");
    @(negedge clk);
    arstn = 1'b1;
    tick(3);

    // Normal READ block: latency, command byte, data, done strobe, gap.
    rxb = rx_bytes.size();
    mb  = mosi_bits.size();
    enable = 1'b1;
    rdy    = 1'b1;
    tick(2);
    check("lat_busy_c2", busy, 0);
    tick();
    check("lat_busy_c3", busy, 1);
    check("lat_mosi_c3", mosi, 0);
    check("lat_cnt_c3", byte_cnt, 0);
    tick(CLKDIV - 1);
    check("sck_before_rise", sck, 0);
    tick();
    check("sck_first_rise", sck, 1);
    n = 0;
    while (block_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("done_seen", block_done, 1);
    check("done_byte_cnt", byte_cnt, BLOCKSIZE);
    rdy = 1'b0;
    count_busy(n);
    check("gap_after_last_bit", n, GAP + 1);
    check_cmd(mb, 8'h01, "read_cmd");
    check_block(rxb, "blk1");
    seen = 0;
    for (int i = mb + 8; i < mosi_bits.size(); i++) if (mosi_bits[i] !== 1'b0) seen++;
    check("data_mosi_zero", seen, 0);
    check("read_rises", mosi_bits.size() - mb, 8 * (BLOCKSIZE + 1));

    // CLR while idle with rdy low.
    tick(5);
    rxb = rx_bytes.size();
    mb  = mosi_bits.size();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_busy(1'b1, 10, "clr_start");
    count_busy(n);
    check("clr_busy_len", n, 16 * CLKDIV + GAP);
    check_cmd(mb, 8'h02, "clr_cmd");
    check("clr_rises", mosi_bits.size() - mb, 8);
    check("clr_no_rvalid", rx_bytes.size(), rxb);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b0) seen++;
    end
    check("clr_single", seen, 0);

    // CLR requested mid-block with rdy held: block finishes, then CLR runs.
    rxb = rx_bytes.size();
    rdy = 1'b1;
    wait_busy(1'b1, 10, "midclr_start");
    n = 0;
    while (rx_bytes.size() < rxb + 2 && n < 200) begin
      tick();
      n++;
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_busy(1'b0, 400, "midclr_read_end");
    check_block(rxb, "blk2");
    rxb = rx_bytes.size();
    mb  = mosi_bits.size();
    wait_busy(1'b1, 10, "midclr_next_start");
    rdy = 1'b0;
    wait_busy(1'b0, 200, "midclr_next_end");
    check_cmd(mb, 8'h02, "midclr_cmd");
    check("midclr_rises", mosi_bits.size() - mb, 8);
    check("midclr_no_rvalid", rx_bytes.size(), rxb);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy !== 1'b0) seen++;
    end
    check("midclr_idle_after", seen, 0);

    // rdy dropped right after the block starts.
    rxb = rx_bytes.size();
    rdy = 1'b1;
    wait_busy(1'b1, 10, "rdydrop_start");
    rdy = 1'b0;
    wait_busy(1'b0, 400, "rdydrop_end");
    check_block(rxb, "blk3");
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy !== 1'b0) seen++;
    end
    check("rdydrop_no_restart", seen, 0);

    // Asynchronous reset during byte 2.
    rxb = rx_bytes.size();
    rdy = 1'b1;
    wait_busy(1'b1, 10, "rst_start");
    n = 0;
    while (rx_bytes.size() < rxb + 1 && n < 200) begin
      tick();
      n++;
    end
    tick(8);
    #1 arstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(5);
    check("midrst_no_rvalid", rx_bytes.size(), rxb + 1);
    arstn = 1'b1;
    rxb = rx_bytes.size();
    wait_busy(1'b1, 10, "rst_restart");
    check("rst_restart_cnt", byte_cnt, 0);
    rdy = 1'b0;
    wait_busy(1'b0, 400, "rst_restart_end");
    check_block(rxb, "blk4");

    // enable low: rdy alone must not start anything.
    tick(5);
    enable = 1'b0;
    rdy    = 1'b1;
    seen   = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (sck !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("disabled_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
